uart_tx_serial: RTL and testbench

Serial transmitter that sits directly downstream of the CSCv2 CPU in the FPGA build, in place of the simulation-only character printer. On each rising edge of the CPU's TX strobe it captures the 8-bit A:B byte into a small FIFO, then shifts queued bytes out as 8N1 asynchronous serial, LSB first. Sticky overflow and busy indication are provided because the CPU has no back-pressure input.

---
 rtl/uart_tx_serial.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_serial.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serial.sv
// uart_tx_serial: byte-wide 8N1 serial transmitter with a small input FIFO.
// A rising edge on tx_req queues the byte on data; queued bytes are shifted
// out LSB first on serial_out, back-to-back when the FIFO is not empty.
//
// Ports:
//   dblclk      system clock, all state changes on the rising edge
//   reset       synchronous, active-low
//   data        byte to queue (CPU A in [7:4], B in [3:0])
//   tx_req      TX strobe (level); a push happens on its rising edge
//   serial_out  registered serial line, idles high
//   busy        FIFO non-empty or a frame in progress
//   overflow    sticky, set when a byte is dropped on a full FIFO
//   fifo_count  queued bytes, not counting the one being shifted
module uart_tx_serial #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic               dblclk,
  input  logic               reset,
  input  logic [7:0]         data,
  input  logic               tx_req,
  output logic               serial_out,
  output logic               busy,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned BW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               ser_q, ser_d;
  logic               ovf_q, ovf_d;
  logic               tx_req_q, tx_req_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         mem_q [DEPTH];

  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               fifo_empty;
  logic               baud_done;
  logic [7:0]         head;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    ser_d      = ser_q;
    pop        = 1'b0;
    push_req   = tx_req & ~tx_req_q;
    tx_req_d   = tx_req;
    fifo_empty = (count_q == '0);
    baud_done  = (baud_q == BAUD_LAST);
    head       = mem_q[rd_ptr_q];

    // ser_d always carries the level of the bit period being entered, so the
    // line changes on the same edge as the state.
    case (state_q)
      IDLE: begin
        ser_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          state_d = START;
          ser_d   = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          ser_d   = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            ser_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            ser_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            ser_d   = 1'b0;
          end else begin
            state_d = IDLE;
            ser_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ser_d   = 1'b1;
      end
    endcase

    // A full FIFO still accepts a push when a pop frees the head slot on the
    // same edge; the pop reads the old head before the write lands.
    push_ok  = push_req & (~count_q[FIFO_AW] | pop);
    ovf_d    = ovf_q | (push_req & ~push_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge dblclk) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      ser_q    <= 1'b1;
      ovf_q    <= 1'b0;
      tx_req_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      ser_q    <= ser_d;
      ovf_q    <= ovf_d;
      tx_req_q <= tx_req_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge dblclk) begin
    if (reset && push_ok) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  assign serial_out = ser_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) | (count_q != '0);

endmodule

// File: tb/tb_uart_tx_serial.sv
module tb_uart_tx_serial;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 2;

  logic          dblclk = 1'b0;
  logic          reset  = 1'b0;
  logic          tx_req = 1'b1;
  logic [7:0]    data   = '0;
  logic          serial_out;
  logic          busy;
  logic          overflow;
  logic [AW:0]   fifo_count;

  int checks   = 0;
  int failures = 0;

  logic cap_en = 1'b0;
  logic cap_q[$];

  typedef struct {
    logic        rst_n;
    logic        req;
    logic [7:0]  d;
    logic        s;
    logic        b;
    logic        o;
    logic [AW:0] c;
  } vec_t;

  vec_t vecs[$];

  uart_tx_serial #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .dblclk     (dblclk),
    .reset      (reset),
    .data       (data),
    .tx_req     (tx_req),
    .serial_out (serial_out),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 dblclk = ~dblclk;

  // Line recorder: one sample per cycle, taken shortly after the active edge.
  always @(posedge dblclk) begin
    #2;
    if (cap_en) cap_q.push_back(serial_out);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge dblclk);
    @(negedge dblclk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic r, input logic q, input logic [7:0] d,
                                  input logic s, input logic b, input logic o,
                                  input logic [AW:0] c);
    vec_t v;
    v.rst_n = r; v.req = q; v.d = d; v.s = s; v.b = b; v.o = o; v.c = c;
    vecs.push_back(v);
  endfunction

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic pulse(input logic [7:0] b);
    tx_req = 1'b1;
    data   = b;
    tick();
    tx_req = 1'b0;
  endtask

  // Entered at the first start-bit sample; leaves one cycle after the stop bit.
  task automatic check_frame(input string name, input logic [7:0] b);
    logic [9:0] f;
    logic       act;
    f = frame_of(b);
    for (int i = 0; i < 10; i++) begin
      act = f[i];
      for (int j = 0; j < int'(CPB); j++) begin
        if (serial_out !== f[i] && act === f[i]) act = serial_out;
        tick();
      end
      chk($sformatf("%s bit%0d", name, i), 32'(act), 32'(f[i]));
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic check_stream(input string name, input logic [7:0] bytes[$], input int exp_start);
    int         st;
    int         idx;
    logic [9:0] f;
    logic       act;
    logic       tail_ok;
    st = -1;
    for (int k = 0; k < cap_q.size(); k++) begin
      if (cap_q[k] === 1'b0) begin
        st = k;
        break;
      end
    end
    chk($sformatf("%s start index", name), 32'(st), 32'(exp_start));
    for (int fr = 0; fr < bytes.size(); fr++) begin
      f = frame_of(bytes[fr]);
      for (int i = 0; i < 10; i++) begin
        act = f[i];
        for (int j = 0; j < int'(CPB); j++) begin
          idx = st + fr * 10 * int'(CPB) + i * int'(CPB) + j;
          if (idx < 0 || idx >= cap_q.size()) act = 1'bx;
          else if (cap_q[idx] !== f[i] && act === f[i]) act = cap_q[idx];
        end
        chk($sformatf("%s frame%0d bit%0d", name, fr, i), 32'(act), 32'(f[i]));
      end
    end
    tail_ok = 1'b1;
    idx = st + bytes.size() * 10 * int'(CPB);
    if (idx < 0 || idx + 4 > cap_q.size()) tail_ok = 1'b0;
    else for (int k = idx; k < cap_q.size(); k++) if (cap_q[k] !== 1'b1) tail_ok = 1'b0;
    chk($sformatf("%s idle tail", name), 32'(tail_ok), 32'd1);
  endtask

  initial begin
    logic [9:0] fa5;
    logic [7:0] eb[$];

    // Vector table: reset behaviour with held strobe, then a single 8'hA5 frame.
    fa5 = frame_of(8'hA5);
    repeat (3)  add_vec(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (10) add_vec(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (2)  add_vec(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    add_vec(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 3'd1);
    add_vec(1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int k = 1; k < 40; k++)
      add_vec(1'b1, 1'b0, 8'hA5, fa5[k / 4], 1'b1, 1'b0, 3'd0);
    repeat (3)  add_vec(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 3'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst_n;
      tx_req = vecs[i].req;
      data   = vecs[i].d;
      tick();
      chk($sformatf("vec%0d serial_out", i), 32'(serial_out), 32'(vecs[i].s));
      chk($sformatf("vec%0d busy", i),       32'(busy),       32'(vecs[i].b));
      chk($sformatf("vec%0d overflow", i),   32'(overflow),   32'(vecs[i].o));
      chk($sformatf("vec%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].c));
    end

    // Held strobe: one frame for 50 cycles high, a second after re-arming.
    tx_req = 1'b1;
    data   = 8'h3C;
    tick();
    chk("held push count", 32'(fifo_count), 32'd1);
    tick();
    chk("held latency", 32'(serial_out), 32'd0);
    check_frame("held 3C", 8'h3C);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("held no refire %0d", k), 32'({busy, serial_out}), 32'b01);
      tick();
    end
    tx_req = 1'b0;
    tick();
    tx_req = 1'b1;
    data   = 8'hC3;
    tick();
    tick();
    chk("rearm latency", 32'(serial_out), 32'd0);
    check_frame("rearm C3", 8'hC3);
    tx_req = 1'b0;
    chk("rearm idle busy", 32'(busy), 32'd0);
    repeat (3) tick();

    // Burst of six: five sent back-to-back, sixth dropped.
    cap_q.delete();
    cap_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      pulse(8'(k));
      chk($sformatf("burst count after push %0d", k), 32'(fifo_count),
          (k == 1) ? 32'd1 : ((k - 1 > 4) ? 32'd4 : 32'(k - 1)));
      chk($sformatf("burst overflow after push %0d", k), 32'(overflow),
          (k == 6) ? 32'd1 : 32'd0);
      if (k < 6) begin
        tick();
        tick();
      end
    end
    wait_idle("burst drain", 600);
    repeat (12) tick();
    cap_en = 1'b0;
    for (int k = 1; k <= 5; k++) eb.push_back(8'(k));
    check_stream("burst", eb, 1);
    chk("burst overflow sticky", 32'(overflow), 32'd1);
    chk("burst final count", 32'(fifo_count), 32'd0);

    // Collision: push lands on the STOP-to-START pop with the FIFO full.
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("collision pre overflow", 32'(overflow), 32'd0);
    cap_q.delete();
    cap_en = 1'b1;
    pulse(8'h11);
    for (int k = 2; k <= 5; k++) begin
      tick();
      tick();
      pulse(8'(8'h10 + k));
    end
    repeat (28) tick();
    chk("collision full count", 32'(fifo_count), 32'd4);
    chk("collision stop level", 32'(serial_out), 32'd1);
    pulse(8'h16);
    chk("collision count", 32'(fifo_count), 32'd4);
    chk("collision overflow", 32'(overflow), 32'd0);
    chk("collision next start", 32'(serial_out), 32'd0);
    wait_idle("collision drain", 700);
    repeat (12) tick();
    cap_en = 1'b0;
    eb.delete();
    for (int k = 1; k <= 6; k++) eb.push_back(8'(8'h10 + k));
    check_stream("collision", eb, 1);
    chk("collision final overflow", 32'(overflow), 32'd0);

    // Reset mid-frame during data bit 3, with a second byte queued.
    pulse(8'h5A);
    tick();
    tick();
    pulse(8'h77);
    chk("midreset queued", 32'(fifo_count), 32'd1);
    repeat (14) tick();
    chk("midreset in bit3", 32'(serial_out), 32'd1);
    reset = 1'b0;
    tick();
    chk("midreset serial_out", 32'(serial_out), 32'd1);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset fifo_count", 32'(fifo_count), 32'd0);
    chk("midreset overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    tx_req = 1'b1;
    data   = 8'hC9;
    tick();
    chk("post reset push", 32'(fifo_count), 32'd1);
    tick();
    chk("post reset latency", 32'(serial_out), 32'd0);
    check_frame("post reset C9", 8'hC9);
    tx_req = 1'b0;
    chk("post reset done busy", 32'(busy), 32'd0);
    repeat (10) tick();
    chk("post reset stays idle", 32'({busy, serial_out}), 32'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
